if_fetch_ctrl: RTL
==================

// Module: if_fetch_ctrl
// PURPOSE
//  Sequencer for the IF stage and its instruction memory port. Boot-loads program words into
//  instruction memory from INS_START, then releases IF to fetch. Shares the single memory port
//  between loader writes and IF reads, and stalls IF on memory wait states.
//  Turns control_j into a one-cycle IF/ID flush, and halts on out-of-range or misaligned fetches.
// PARAMETERS
//  INS_START     64   byte address of instruction word 0; PC value that IF uses after reset
//  INS_MEM_SIZE  40   instruction memory depth in 32-bit words
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-high; returns block to BOOT
//  load_valid  in   1   loader offers load_data
//  load_data   in   32  program word, little-endian as stored in memory
//  load_last   in   1   qualifies final loader word
//  load_ready  out  1   block accepts loader word this cycle
//  ins_addr    in   32  IF fetch address (byte)
//  control_j   in   1   jump/redirect request from ID
//  mem_en      out  1   memory port access strobe
//  mem_we      out  1   1 = write (loader), 0 = read (fetch)
//  mem_addr    out  32  byte address to memory
//  mem_wdata   out  32  write data
//  mem_ready   in   1   memory completes the access this cycle (read data valid)
//  if_hold     out  1   freeze IF PC and pipe registers
//  if_flush    out  1   zero IF/ID pipe_data (bubble) this cycle
//  boot_done   out  1   program loaded, fetch enabled
//  fault       out  1   sticky: load overflow, fetch out of range, or misaligned fetch
// BEHAVIOUR
//  States: BOOT -> RUN <-> WAIT; RUN/WAIT -> HALT. Reset enters BOOT from any state, word count 0.
//  Reset values: load_ready=1, mem_en=0, mem_we=0, mem_addr=INS_START, mem_wdata=0, if_hold=1,
//   if_flush=0, boot_done=0, fault=0.
//  BOOT: load_ready=1, if_hold=1. A word transfers on load_valid&load_ready&mem_ready:
//   mem_en=1, mem_we=1, mem_addr=INS_START+4*cnt, cnt++. While mem_ready=0, the word is not
//   accepted: load_ready drops for that cycle and the offer is held.
//   A transfer with load_last -> RUN next cycle, boot_done=1.
//   Offer when cnt==INS_MEM_SIZE: word dropped, fault=1, -> RUN.
//  RUN: mem_en=1, mem_we=0, mem_addr=ins_addr, if_hold=0.
//   If mem_ready=0: if_hold=1 combinationally the same cycle, -> WAIT.
//  WAIT: if_hold=1, mem_addr held at the stalled address; -> RUN in the cycle mem_ready=1
//   (if_hold deasserts that cycle).
//  control_j in RUN with mem_ready=1: if_flush=1 that cycle; IF has the redirect.
//   control_j in WAIT: latched as pending. if_flush=1 in the cycle WAIT exits; pending clears.
//   A second control_j while pending: merged, still one flush.
//  Range check: ins_addr<INS_START, ins_addr>=INS_START+4*INS_MEM_SIZE, or ins_addr[1:0]!=0
//   -> HALT next edge, fault=1, mem_en=0.
//  HALT: if_hold=1, mem_en=0, if_flush=0. Exit only by reset.
//  Address arithmetic: 32-bit unsigned, no wrap check beyond the range test.
//  cnt is ceil(log2(INS_MEM_SIZE+1)) bits.
//  Reset mid-load or mid-wait: pending jump cleared, partial program is kept in memory
//   but cnt restarts at 0.
// CONFIGURATION
//  IF_FETCH_STALL_CNT_EN defined: adds output stall_cnt[31:0]. It counts cycles with if_hold=1
//   in RUN/WAIT only (not BOOT/HALT), saturates at 32'hFFFFFFFF, and resets to 0.
//  Undefined: no port, no counter logic.
// TESTING
//  1 reset, load 3 words (last on 3rd), mem_ready=1 -> mem_addr 64,68,72 with mem_we=1;
//    boot_done=1 on cycle 4; if_hold=0.
//  2 RUN, ins_addr 64->68 with mem_ready low 2 cycles at 68 -> if_hold=1 for 2 cycles,
//    mem_addr stays 68, release on the 3rd.
//  3 control_j in RUN -> if_flush=1 exactly one cycle; control_j during WAIT ->
//    if_flush=1 in the cycle mem_ready returns.
//  4 41 loader words without last -> 40 writes (64..220), 41st dropped, fault=1,
//    state RUN.
//  5 ins_addr=224 (or 66) in RUN -> HALT, fault=1, mem_en=0, if_hold=1; reset ->
//    BOOT, all outputs at reset values.
//  6 with IF_FETCH_STALL_CNT_EN, case 2 -> stall_cnt=2; reset asserted during WAIT ->
//    stall_cnt=0, pending cleared.

Source files
------------

// File: rtl/if_fetch_ctrl_if.sv
// Bus bundle for if_fetch_ctrl: loader handshake, IF fetch request/control, and the shared
// instruction-memory port. 'master' is the controller side, 'slave' the loader/IF/memory side.
interface if_fetch_ctrl_if;

    // Loader handshake
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;

    // IF request and control
    logic [31:0] ins_addr;
    logic        control_j;
    logic        if_hold;
    logic        if_flush;
    logic        boot_done;
    logic        fault;

    // Instruction memory port
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;

    // Controller view
    modport master (
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready,
        input  ins_addr,
        input  control_j,
        output if_hold,
        output if_flush,
        output boot_done,
        output fault,
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready
    );

    // Loader / IF / memory view
    modport slave (
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready,
        output ins_addr,
        output control_j,
        input  if_hold,
        input  if_flush,
        input  boot_done,
        input  fault,
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready
    );

endinterface

// File: rtl/if_fetch_ctrl.sv
// IF-stage sequencer: boot-loads program words into instruction memory starting at INS_START,
// then hands the single memory port to IF fetches, stalls IF on memory wait states, turns
// control_j into a single IF/ID flush, and halts on out-of-range or misaligned fetches.
// Optional feature macro: IF_FETCH_STALL_CNT_EN adds the stall_cnt output (held-cycle counter).
module if_fetch_ctrl #(
    parameter int unsigned INS_START    = 64,
    parameter int unsigned INS_MEM_SIZE = 40
) (
    input  logic            clk,
    input  logic            reset,
    if_fetch_ctrl_if.master bus
`ifdef IF_FETCH_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(INS_MEM_SIZE + 1);

    localparam logic [ADDR_W-1:0] ADDR_LO = ADDR_W'(INS_START);
    localparam logic [ADDR_W-1:0] ADDR_HI = ADDR_W'(INS_START + 4 * INS_MEM_SIZE);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(INS_MEM_SIZE);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              fault_q;
    logic              boot_done_q;
    logic              pend_q;
    logic [ADDR_W-1:0] stall_addr_q;

    logic              in_fetch_c;
    logic              load_full_c;
    logic              load_xfer_c;
    logic              load_drop_c;
    logic [ADDR_W-1:0] load_addr_c;
    logic [ADDR_W-1:0] fetch_addr_c;
    logic              addr_bad_c;

    logic              load_ready_c;
    logic              mem_en_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              if_hold_c;
    logic              if_flush_c;

    // Loader and fetch qualifiers shared by the next-state and output logic
    assign in_fetch_c   = (state_q == ST_RUN) || (state_q == ST_WAIT);
    assign load_full_c  = (cnt_q == CNT_MAX);
    assign load_xfer_c  = (state_q == ST_BOOT) && bus.load_valid && bus.mem_ready && !load_full_c;
    assign load_drop_c  = (state_q == ST_BOOT) && bus.load_valid && load_full_c;
    assign load_addr_c  = ADDR_LO + (ADDR_W'(cnt_q) << 2);
    assign fetch_addr_c = (state_q == ST_WAIT) ? stall_addr_q : bus.ins_addr;
    assign addr_bad_c   = (fetch_addr_c < ADDR_LO) || (fetch_addr_c >= ADDR_HI) ||
                          (fetch_addr_c[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: begin
                if (load_drop_c) begin
                    state_d = ST_RUN;
                end else if (load_xfer_c && bus.load_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_WAIT: begin
                if (addr_bad_c) begin
                    state_d = ST_HALT;
                end else if (bus.mem_ready) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Output logic: memory port mux, loader backpressure, IF hold and flush
    always_comb begin
        load_ready_c = 1'b0;
        mem_en_c     = 1'b0;
        mem_we_c     = 1'b0;
        mem_addr_c   = ADDR_LO;
        mem_wdata_c  = '0;
        if_hold_c    = 1'b1;
        if_flush_c   = 1'b0;
        case (state_q)
            ST_BOOT: begin
                // An offer that the memory cannot take this cycle is backpressured, not lost
                load_ready_c = !(bus.load_valid && !bus.mem_ready && !load_full_c);
                mem_addr_c   = load_addr_c;
                if (load_xfer_c) begin
                    mem_en_c    = 1'b1;
                    mem_we_c    = 1'b1;
                    mem_wdata_c = bus.load_data;
                end
            end
            ST_RUN, ST_WAIT: begin
                mem_addr_c = fetch_addr_c;
                if (!addr_bad_c) begin
                    mem_en_c   = 1'b1;
                    if_hold_c  = !bus.mem_ready;
                    if_flush_c = bus.mem_ready && (bus.control_j || pend_q);
                end
            end
            default: begin
                if_hold_c = 1'b1;
            end
        endcase
    end

    // Loader word count; restarts on reset while memory contents stay as written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_xfer_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Boot completion and sticky fault flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            boot_done_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            if ((state_q == ST_BOOT) && (state_d == ST_RUN)) begin
                boot_done_q <= 1'b1;
            end
            if (load_drop_c || (in_fetch_c && addr_bad_c)) begin
                fault_q <= 1'b1;
            end
        end
    end

    // Jump requests arriving while the fetch is stalled are merged into one pending flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= 1'b0;
        end else if (in_fetch_c) begin
            if (addr_bad_c || bus.mem_ready) begin
                pend_q <= 1'b0;
            end else if (bus.control_j) begin
                pend_q <= 1'b1;
            end
        end else begin
            pend_q <= 1'b0;
        end
    end

    // Capture the fetch address that the memory stalled on
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_addr_q <= ADDR_LO;
        end else if ((state_q == ST_RUN) && !addr_bad_c && !bus.mem_ready) begin
            stall_addr_q <= bus.ins_addr;
        end
    end

`ifdef IF_FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of held cycles while fetching
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (in_fetch_c && if_hold_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign bus.load_ready = load_ready_c;
    assign bus.mem_en     = mem_en_c;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wdata  = mem_wdata_c;
    assign bus.if_hold    = if_hold_c;
    assign bus.if_flush   = if_flush_c;
    assign bus.boot_done  = boot_done_q;
    assign bus.fault      = fault_q;

endmodule
